booth_divider_seq: RTL and testbench
====================================

Name: booth_divider_seq

Overview:
- Sequential unsigned restoring divider: the inverse of the team's 3x3 Booth multiplier datapath.
- Takes a 2W-bit dividend (product-width) and a W-bit divisor; returns W-bit quotient and W-bit remainder after W iteration cycles.
- Contains its own control FSM and start/done handshake.
- Sits beside the multiplier so a product can be fed back and checked.

Parameters:
W, 3, operand width; dividend is 2W bits, divisor/quotient/remainder are W bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  2W  unsigned dividend, sampled with start
divisor  input  W  unsigned divisor, sampled with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  W  registered quotient
remainder  output  W  registered remainder
ovf  output  1  registered; quotient does not fit W bits, or divide-by-zero

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset (any state, including mid-operation): state=IDLE; busy=0, done=0, quotient=0, remainder=0, ovf=0; internal A, Q, D, count cleared.
- FSM states: IDLE, RUN, FIN.
- IDLE with start=1 at edge 0: overflow check uses the inputs combinationally; condition is dividend[2W-1:W] >= divisor, which covers divisor=0.
  - Overflow: go to FIN; latch ovf=1, quotient={W{1}}, remainder=0.
  - Otherwise: A (W+1 bits) = {0, dividend[2W-1:W]}; Q = dividend[W-1:0]; D = divisor; count = W; go to RUN.
- RUN, one iteration per cycle:
  - Shift {A,Q} left 1 to form A', Q'.
  - T = A' - {0,D}, W+1 bits.
  - T[W]=0: A=T, Q={Q'[W-1:1],1}.
  - Else: A=A', Q={Q'[W-1:1],0}.
  - Decrement count. On the edge where count goes 1->0: quotient=Q(new), remainder=A(new)[W-1:0], ovf=0; go to FIN.
- FIN: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Latency: done is high in the cycle after edge W (non-overflow), or after edge 0 (overflow).
- Throughput: one division per W+2 cycles. start in FIN is ignored; a new start is accepted one cycle after done.
- start while in RUN or FIN is ignored; dividend and divisor are not re-sampled.
- Outputs hold their value until the next accepted start completes (or reset); they do not change on start acceptance.
- No-overflow invariant: A[W] = 0 before each shift, so W+1 bits suffice. A remainder < divisor is guaranteed.
- Arithmetic is unsigned only. Signed operands are out of scope; callers pass magnitudes.

Decomposition:
- Shared include div_defs.vh: FSM state encodings (IDLE=2'b00, RUN=2'b01, FIN=2'b10); count width macro CLOG2(W+1).
- One sub-module, div_step: combinational shift-subtract-select. Inputs A, Q, D; outputs A_next, Q_next.
- Top holds the registers and FSM.

Test Plan:
- W=3, dividend=23, divisor=5, start 1 cycle -> done 3 cycles after start edge; quotient=4, remainder=3, ovf=0; busy high for 4 cycles.
- dividend=55, divisor=7 -> quotient=7, remainder=6, ovf=0 (max quotient, no overflow). dividend=0, divisor=3 -> quotient=0, remainder=0.
- dividend=10, divisor=0 -> done on cycle after start edge; ovf=1, quotient=7, remainder=0. dividend=40, divisor=5 (high half 5>=5) -> same overflow response.
- Pulse start again during RUN with different operands (9/2) -> ignored; first result (23/5) returned; start held high through FIN -> new division begins only after IDLE is reached.
- Assert reset during RUN cycle 2 of 23/5 -> next cycle: busy=0, done=0, outputs=0; no done pulse ever follows; a subsequent 23/5 completes normally.
- Exhaustive sweep: all 64 dividends x 8 divisors -> compare with a reference model: ovf when (dividend>>3) >= divisor; otherwise quotient*divisor + remainder == dividend and remainder < divisor.

Source files
------------

// File: rtl/booth_divider_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
// - state_t   : control FSM state encoding (IDLE, RUN, FIN)
// - cnt_width : width of the iteration counter needed to hold the value w
package booth_divider_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/booth_divider_seq_div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   a      : partial remainder A (W+1 bits)
//   q      : dividend low half / quotient being built (W bits)
//   d      : divisor (W bits)
//   a_next : A after shift and conditional subtract
//   q_next : Q after shift, with the new quotient bit in bit 0
module booth_divider_seq_div_step #(
  parameter int unsigned W = 3
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W:0]   a_next,
  output logic [W-1:0] q_next
);

  logic [W+1:0] a_sh;
  logic [W+1:0] t;

  // The shift is kept one bit wider than A so the subtract sign is exact even
  // if A[W] were set; with A < D it always matches the W+1-bit sign bit.
  always_comb begin
    a_sh   = {a, q[W-1]};
    t      = a_sh - {2'b00, d};
    q_next = q << 1;
    if (!t[W+1]) begin
      a_next    = t[W:0];
      q_next[0] = 1'b1;
    end else begin
      a_next    = a_sh[W:0];
    end
  end

endmodule

// File: rtl/booth_divider_seq.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor,
// W iteration cycles, with start/done handshake.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   start               : request, sampled only in IDLE with dividend/divisor
//   dividend, divisor   : unsigned operands
//   busy                : high whenever the FSM is not in IDLE
//   done                : one-cycle pulse; results valid from this cycle
//   quotient, remainder : registered results, held until the next completion
//   ovf                 : quotient does not fit W bits, or divide-by-zero
module booth_divider_seq
  import booth_divider_seq_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf
);

  localparam int unsigned CW = cnt_width(W);

  state_t        state, state_next;
  logic [W:0]    a_r;
  logic [W-1:0]  q_r;
  logic [W-1:0]  d_r;
  logic [CW-1:0] cnt;

  logic [W:0]    a_step;
  logic [W-1:0]  q_step;
  logic          ovf_in;
  logic          load;
  logic          ovf_load;
  logic          last;

  booth_divider_seq_div_step #(.W(W)) u_step (
    .a      (a_r),
    .q      (q_r),
    .d      (d_r),
    .a_next (a_step),
    .q_next (q_step)
  );

  // High half >= divisor means the quotient needs more than W bits; this
  // also catches divisor == 0.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    ovf_load   = 1'b0;
    last       = 1'b0;
    ovf_in     = (dividend[2*W-1:W] >= divisor);
    case (state)
      IDLE: begin
        if (start) begin
          if (ovf_in) begin
            ovf_load   = 1'b1;
            state_next = FIN;
          end else begin
            load       = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          last       = 1'b1;
          state_next = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r       <= '0;
      q_r       <= '0;
      d_r       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
    end else begin
      if (load) begin
        a_r <= {1'b0, dividend[2*W-1:W]};
        q_r <= dividend[W-1:0];
        d_r <= divisor;
        cnt <= CW'(W);
      end else if (state == RUN) begin
        a_r <= a_step;
        q_r <= q_step;
        cnt <= cnt - CW'(1);
      end

      // Results only move on completion, never on start acceptance.
      if (ovf_load) begin
        ovf       <= 1'b1;
        quotient  <= '1;
        remainder <= '0;
      end else if (last) begin
        ovf       <= 1'b0;
        quotient  <= q_step;
        remainder <= a_step[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_divider_seq.sv
// Self-checking bench for booth_divider_seq (W=3): directed vectors,
// handshake/timing cases, mid-operation reset, and a full operand sweep.
module tb_booth_divider_seq;

  localparam int unsigned W = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           ovf;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  booth_divider_seq #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_op(input int unsigned dd, input int unsigned dv);
    @(negedge clk);
    dividend = 6'(dd);
    divisor  = 3'(dv);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // edges: posedges after the start edge until done is seen.
  task automatic wait_done(input int unsigned limit, output int unsigned edges,
                           output int unsigned busyc, output bit ok);
    int unsigned n;
    n = 0;
    busyc = 0;
    ok = 1'b0;
    while (n < limit && !ok) begin
      @(negedge clk);
      n++;
      if (busy) busyc++;
      if (done) ok = 1'b1;
    end
    edges = n - 1;
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_div(input string tag, input int unsigned dd, input int unsigned dv,
                         input int unsigned eq, input int unsigned er, input int unsigned eo,
                         input int unsigned elat, input int unsigned ebusy);
    int unsigned edges, busyc;
    bit ok;
    start_op(dd, dv);
    wait_done(20, edges, busyc, ok);
    if (ok) begin
      check({tag, "_lat"}, edges, elat);
      check({tag, "_busycyc"}, busyc, ebusy);
      check({tag, "_q"}, quotient, eq);
      check({tag, "_r"}, remainder, er);
      check({tag, "_ovf"}, ovf, eo);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_hold_q"}, quotient, eq);
    end
  endtask

  initial begin
    int unsigned edges, busyc;
    bit ok, seen;

    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_ovf", ovf, 0);

    run_div("d23_5", 23, 5, 4, 3, 0, 3, 4);
    run_div("d55_7", 55, 7, 7, 6, 0, 3, 4);
    run_div("d0_3", 0, 3, 0, 0, 0, 3, 4);
    run_div("d10_0", 10, 0, 7, 0, 1, 0, 1);
    run_div("d40_5", 40, 5, 7, 0, 1, 0, 1);

    // start pulsed and then held from the first RUN cycle with other operands
    start_op(23, 5);
    @(negedge clk);
    dividend = 6'd9;
    divisor  = 3'd2;
    start    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("held_done", done, 1);
    check("held_q_first", quotient, 4);
    check("held_r_first", remainder, 3);
    @(negedge clk);
    check("start_in_fin_ignored", busy, 0);
    @(negedge clk);
    check("accept_after_idle", busy, 1);
    check("hold_on_accept_q", quotient, 4);
    check("hold_on_accept_r", remainder, 3);
    start = 1'b0;
    wait_done(20, edges, busyc, ok);
    if (ok) begin
      check("d9_2_q", quotient, 4);
      check("d9_2_r", remainder, 1);
      check("d9_2_ovf", ovf, 0);
    end

    // reset during RUN cycle 2
    start_op(23, 5);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_ovf", ovf, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("no_done_after_rst", seen, 0);
    run_div("post_rst_23_5", 23, 5, 4, 3, 0, 3, 4);

    // full sweep against an arithmetic reference
    for (int dd = 0; dd < 64; dd++) begin
      for (int dv = 0; dv < 8; dv++) begin
        bit eo;
        start_op(dd, dv);
        wait_done(20, edges, busyc, ok);
        if (ok) begin
          eo = ((dd >> 3) >= dv);
          check($sformatf("sw_ovf_%0d_%0d", dd, dv), ovf, eo);
          if (eo) begin
            check($sformatf("sw_q_%0d_%0d", dd, dv), quotient, 7);
            check($sformatf("sw_r_%0d_%0d", dd, dv), remainder, 0);
          end else begin
            check($sformatf("sw_qdr_%0d_%0d", dd, dv), quotient * dv + remainder, dd);
            check($sformatf("sw_rlt_%0d_%0d", dd, dv), remainder < dv, 1);
            check($sformatf("sw_q_%0d_%0d", dd, dv), quotient, dd / dv);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
